bot_io_arbiter: RTL and testbench

- Two-master arbiter and sequencer for the port-mapped I/O bus of the robot system interface block (port_id / data-in / write_strobe / read_strobe / registered read data).
- Master 0 is normally the PicoBlaze-side adapter; master 1 is a hardware sequencer or debug master.
- Round-robin grant; each granted transaction is sequenced as a single-cycle write strobe, or as a read strobe followed by a fixed-latency capture of the registered read data.

---
 rtl/bot_io_arbiter.sv | 152 +++++++++++++++
 tb/tb_bot_io_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bot_io_arbiter.sv
// Two-master round-robin arbiter/sequencer for the port-mapped I/O bus.
// Optional bus-hold (lock) support is built when BOT_ARB_LOCK_EN is defined.
module bot_io_arbiter #(
   parameter int READ_LAT = 1
) (
   input  logic       sysclk,
   input  logic       sysreset,
   input  logic       req0,
   input  logic       req1,
   input  logic       we0,
   input  logic       we1,
   input  logic [7:0] addr0,
   input  logic [7:0] addr1,
   input  logic [7:0] wdata0,
   input  logic [7:0] wdata1,
   input  logic       lock0,
   input  logic       lock1,
   output logic [1:0] gnt,
   output logic       ack0,
   output logic       ack1,
   output logic [7:0] rdata,
   output logic [7:0] port_id,
   output logic [7:0] io_data_out,
   output logic       write_strobe,
   output logic       read_strobe,
   input  logic [7:0] bus_rdata,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, XFER, RWAIT, DONE} state_t;

   state_t     state_reg;
   logic       owner_reg;
   logic       we_reg;
   logic       last_grant_reg;
   logic [1:0] cnt_reg;

   logic       win_next;
   logic       lock_grant_next;
   logic       sel_we_next;
   logic [7:0] sel_addr_next;
   logic [7:0] sel_wdata_next;

`ifdef BOT_ARB_LOCK_EN
   logic       lock_arm_reg;
   logic [2:0] hold_cnt_reg;
`else
   logic       unused_lock;
   assign unused_lock = lock0 ^ lock1;
`endif

   // Winner selection; a tie goes to the master that did not win last time.
   always_comb begin
      win_next        = 1'b0;
      lock_grant_next = 1'b0;
      if (req0 && req1)
         win_next = ~last_grant_reg;
      else
         win_next = req1;
`ifdef BOT_ARB_LOCK_EN
      if (lock_arm_reg && (owner_reg ? req1 : req0)) begin
         win_next        = owner_reg;
         lock_grant_next = 1'b1;
      end
`endif
      sel_we_next    = win_next ? we1    : we0;
      sel_addr_next  = win_next ? addr1  : addr0;
      sel_wdata_next = win_next ? wdata1 : wdata0;
   end

   always_ff @(posedge sysclk or posedge sysreset) begin
      if (sysreset) begin
         state_reg      <= IDLE;
         owner_reg      <= 1'b0;
         we_reg         <= 1'b0;
         last_grant_reg <= 1'b1;
         cnt_reg        <= 2'd0;
         gnt            <= 2'b00;
         ack0           <= 1'b0;
         ack1           <= 1'b0;
         rdata          <= 8'h00;
         port_id        <= 8'h00;
         io_data_out    <= 8'h00;
         write_strobe   <= 1'b0;
         read_strobe    <= 1'b0;
         busy           <= 1'b0;
`ifdef BOT_ARB_LOCK_EN
         lock_arm_reg   <= 1'b0;
         hold_cnt_reg   <= 3'd0;
`endif
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         case (state_reg)
            IDLE: begin
`ifdef BOT_ARB_LOCK_EN
               lock_arm_reg <= 1'b0;
`endif
               if (req0 || req1) begin
                  owner_reg    <= win_next;
                  we_reg       <= sel_we_next;
                  port_id      <= sel_addr_next;
                  io_data_out  <= sel_wdata_next;
                  gnt          <= win_next ? 2'b10 : 2'b01;
                  write_strobe <= sel_we_next;
                  read_strobe  <= ~sel_we_next;
                  busy         <= 1'b1;
                  state_reg    <= XFER;
                  if (!lock_grant_next)
                     last_grant_reg <= win_next;
`ifdef BOT_ARB_LOCK_EN
                  hold_cnt_reg <= lock_grant_next ? hold_cnt_reg + 3'd1 : 3'd1;
`endif
               end
            end
            XFER: begin
               write_strobe <= 1'b0;
               read_strobe  <= 1'b0;
               if (we_reg) begin
                  ack0      <= ~owner_reg;
                  ack1      <= owner_reg;
                  state_reg <= DONE;
               end else begin
                  cnt_reg   <= 2'(READ_LAT - 1);
                  state_reg <= RWAIT;
               end
            end
            RWAIT: begin
               if (cnt_reg == 2'd0) begin
                  rdata     <= bus_rdata;
                  ack0      <= ~owner_reg;
                  ack1      <= owner_reg;
                  state_reg <= DONE;
               end else begin
                  cnt_reg <= cnt_reg - 2'd1;
               end
            end
            DONE: begin
               gnt       <= 2'b00;
               busy      <= 1'b0;
               state_reg <= IDLE;
`ifdef BOT_ARB_LOCK_EN
               // Re-grant eligibility is decided here and consumed in the next IDLE cycle.
               lock_arm_reg <= (owner_reg ? lock1 : lock0) && (hold_cnt_reg < 3'd4);
`endif
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bot_io_arbiter.sv
// Directed bench for bot_io_arbiter: READ_LAT=1 instance plus a READ_LAT=3 instance.
module tb_bot_io_arbiter;

   logic       sysclk;
   logic       sysreset;
   logic       req0, req1, we0, we1, lock0, lock1;
   logic [7:0] addr0, addr1, wdata0, wdata1;
   logic [1:0] gnt;
   logic       ack0, ack1, write_strobe, read_strobe, busy;
   logic [7:0] rdata, port_id, io_data_out, bus_rdata;

   logic       d3_req0, d3_req1, d3_we0, d3_we1, d3_lock0, d3_lock1;
   logic [7:0] d3_addr0, d3_addr1, d3_wdata0, d3_wdata1;
   logic [1:0] d3_gnt;
   logic       d3_ack0, d3_ack1, d3_write_strobe, d3_read_strobe, d3_busy;
   logic [7:0] d3_rdata, d3_port_id, d3_io_data_out, d3_bus_rdata;
   logic [7:0] d3_p1, d3_p2;

   int tests_run = 0;
   int tests_failed = 0;
   int overlap_cnt = 0;

   bot_io_arbiter #(.READ_LAT(1)) u_dut (
      .sysclk(sysclk), .sysreset(sysreset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .lock0(lock0), .lock1(lock1), .gnt(gnt), .ack0(ack0), .ack1(ack1),
      .rdata(rdata), .port_id(port_id), .io_data_out(io_data_out),
      .write_strobe(write_strobe), .read_strobe(read_strobe),
      .bus_rdata(bus_rdata), .busy(busy)
   );

   bot_io_arbiter #(.READ_LAT(3)) u_dut3 (
      .sysclk(sysclk), .sysreset(sysreset),
      .req0(d3_req0), .req1(d3_req1), .we0(d3_we0), .we1(d3_we1),
      .addr0(d3_addr0), .addr1(d3_addr1), .wdata0(d3_wdata0), .wdata1(d3_wdata1),
      .lock0(d3_lock0), .lock1(d3_lock1), .gnt(d3_gnt), .ack0(d3_ack0), .ack1(d3_ack1),
      .rdata(d3_rdata), .port_id(d3_port_id), .io_data_out(d3_io_data_out),
      .write_strobe(d3_write_strobe), .read_strobe(d3_read_strobe),
      .bus_rdata(d3_bus_rdata), .busy(d3_busy)
   );

   initial begin
      sysclk = 1'b0;
      forever #5 sysclk = ~sysclk;
   end

   // Slave model: data = address ^ 8'h36, registered once (or three times for the slow bus).
   always @(posedge sysclk) begin
      bus_rdata    <= port_id ^ 8'h36;
      d3_p1        <= d3_port_id ^ 8'h36;
      d3_p2        <= d3_p1;
      d3_bus_rdata <= d3_p2;
   end

   always @(negedge sysclk) begin
      if ((write_strobe && read_strobe) || (d3_write_strobe && d3_read_strobe))
         overlap_cnt++;
   end

   task automatic chk(input string name, input int act, input int exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      int         m;
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
      logic [1:0] exp_gnt;
      int         exp_lat;
   } vec_t;

   vec_t vecs[6];

   task automatic drive_req(input int m, input logic r, input logic we, input logic [7:0] a, input logic [7:0] d);
      if (m == 0) begin
         req0 = r; we0 = we; addr0 = a; wdata0 = d;
      end else begin
         req1 = r; we1 = we; addr1 = a; wdata1 = d;
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int cyc = 0, ws = 0, rs = 0, other = 0;
      logic got = 1'b0;
      logic [7:0] pid = 8'h00, wd = 8'h00;
      logic [1:0] g = 2'b00;
      @(negedge sysclk);
      drive_req(v.m, 1'b1, v.we, v.addr, v.wdata);
      while (!got && cyc < 20) begin
         @(negedge sysclk);
         cyc++;
         if (write_strobe) begin ws++; pid = port_id; wd = io_data_out; end
         if (read_strobe) begin rs++; pid = port_id; end
         if ((v.m == 0) ? ack0 : ack1) begin
            got = 1'b1;
            g = gnt;
            drive_req(v.m, 1'b0, v.we, v.addr, v.wdata);
         end
         if ((v.m == 0) ? ack1 : ack0) other++;
      end
      chk($sformatf("v%0d ack_seen", idx), int'(got), 1);
      chk($sformatf("v%0d latency", idx), cyc + 1, v.exp_lat);
      chk($sformatf("v%0d gnt", idx), int'(g), int'(v.exp_gnt));
      chk($sformatf("v%0d port_id", idx), int'(pid), int'(v.addr));
      chk($sformatf("v%0d wstrobes", idx), ws, v.we ? 1 : 0);
      chk($sformatf("v%0d rstrobes", idx), rs, v.we ? 0 : 1);
      chk($sformatf("v%0d other_ack", idx), other, 0);
      if (v.we) chk($sformatf("v%0d io_data_out", idx), int'(wd), int'(v.wdata));
      chk($sformatf("v%0d rdata", idx), int'(rdata), int'(v.exp_rdata));
      @(negedge sysclk);
      chk($sformatf("v%0d busy_after", idx), int'(busy), 0);
      chk($sformatf("v%0d gnt_after", idx), int'(gnt), 0);
   endtask

   task automatic do_reset();
      @(negedge sysclk);
      sysreset = 1'b1;
      @(negedge sysclk);
      sysreset = 1'b0;
   endtask

   // Hold both requests (writes) and record which master is acked, n times.
   task automatic contend(input int n, output int order[6]);
      int got = 0, cyc = 0;
      for (int i = 0; i < 6; i++) order[i] = -1;
      @(negedge sysclk);
      req0 = 1'b1; we0 = 1'b1; addr0 = 8'h20; wdata0 = 8'h11;
      req1 = 1'b1; we1 = 1'b1; addr1 = 8'h21; wdata1 = 8'h22;
      while (got < n && cyc < 200) begin
         @(negedge sysclk);
         cyc++;
         if (ack0) begin order[got] = 0; got++; end
         else if (ack1) begin order[got] = 1; got++; end
      end
      req0 = 1'b0; req1 = 1'b0;
      chk("contend_done", got, n);
      repeat (4) @(negedge sysclk);
   endtask

   initial begin
      int order[6];
      int cyc;
      int acks;
      logic got;
      int exp_lock[5];

      sysreset = 1'b1;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
      d3_req0 = 0; d3_req1 = 0; d3_we0 = 0; d3_we1 = 0; d3_lock0 = 0; d3_lock1 = 0;
      d3_addr0 = 0; d3_addr1 = 0; d3_wdata0 = 0; d3_wdata1 = 0;

      vecs[0] = '{m: 0, we: 1'b1, addr: 8'h09, wdata: 8'hA5, exp_rdata: 8'h00, exp_gnt: 2'b01, exp_lat: 3};
      vecs[1] = '{m: 1, we: 1'b0, addr: 8'h0A, wdata: 8'h00, exp_rdata: 8'h3C, exp_gnt: 2'b10, exp_lat: 4};
      vecs[2] = '{m: 0, we: 1'b0, addr: 8'h55, wdata: 8'h77, exp_rdata: 8'h63, exp_gnt: 2'b01, exp_lat: 4};
      vecs[3] = '{m: 1, we: 1'b1, addr: 8'hFF, wdata: 8'h00, exp_rdata: 8'h63, exp_gnt: 2'b10, exp_lat: 3};
      vecs[4] = '{m: 0, we: 1'b1, addr: 8'h00, wdata: 8'hFF, exp_rdata: 8'h63, exp_gnt: 2'b01, exp_lat: 3};
      vecs[5] = '{m: 1, we: 1'b0, addr: 8'hFF, wdata: 8'h5A, exp_rdata: 8'hC9, exp_gnt: 2'b10, exp_lat: 4};

      repeat (2) @(negedge sysclk);
      sysreset = 1'b0;
      @(negedge sysclk);
      chk("rst gnt", int'(gnt), 0);
      chk("rst busy", int'(busy), 0);
      chk("rst strobes", int'({write_strobe, read_strobe, ack0, ack1}), 0);
      chk("rst port_id", int'(port_id), 0);
      chk("rst rdata", int'(rdata), 0);

      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

      // Contention: strict alternation starting with master 0
      do_reset();
      contend(6, order);
      for (int i = 0; i < 6; i++) chk($sformatf("rr order[%0d]", i), order[i], i % 2);

      // Request dropped after the grant still completes and acks
      @(negedge sysclk);
      drive_req(0, 1'b1, 1'b1, 8'h33, 8'h44);
      @(negedge sysclk);
      drive_req(0, 1'b0, 1'b1, 8'h33, 8'h44);
      @(negedge sysclk);
      chk("drop ack0", int'(ack0), 1);
      repeat (3) @(negedge sysclk);

      // Reset in RWAIT: outputs clear at once, no late ack, master 0 wins next
      @(negedge sysclk);
      drive_req(0, 1'b1, 1'b0, 8'h0A, 8'h00);
      repeat (2) @(negedge sysclk);
      chk("midrd in_rwait busy", int'(busy), 1);
      sysreset = 1'b1;
      #1;
      chk("midrd gnt", int'(gnt), 0);
      chk("midrd busy", int'(busy), 0);
      chk("midrd flags", int'({write_strobe, read_strobe, ack0, ack1}), 0);
      chk("midrd rdata", int'(rdata), 0);
      drive_req(0, 1'b0, 1'b0, 8'h0A, 8'h00);
      @(negedge sysclk);
      sysreset = 1'b0;
      acks = 0;
      repeat (6) begin
         @(negedge sysclk);
         if (ack0 || ack1) acks++;
      end
      chk("midrd no_ack", acks, 0);
      req0 = 1'b1; we0 = 1'b1; req1 = 1'b1; we1 = 1'b1;
      @(negedge sysclk);
      chk("midrd next_gnt", int'(gnt), 1);
      req0 = 1'b0; req1 = 1'b0;
      repeat (4) @(negedge sysclk);

      // READ_LAT=3 instance: capture lands on the third bus cycle
      d3_req0 = 1'b1; d3_we0 = 1'b0; d3_addr0 = 8'h0A;
      cyc = 0; got = 1'b0;
      while (!got && cyc < 20) begin
         @(negedge sysclk);
         cyc++;
         if (d3_ack0) begin got = 1'b1; d3_req0 = 1'b0; end
      end
      chk("lat3 ack_seen", int'(got), 1);
      chk("lat3 latency", cyc + 1, 6);
      chk("lat3 rdata", int'(d3_rdata), 8'h3C);
      chk("lat3 gnt", int'(d3_gnt), 1);
      @(negedge sysclk);
      chk("lat3 busy_after", int'(d3_busy), 0);

      // Lock: master 0 holds the bus for up to four transactions
`ifdef BOT_ARB_LOCK_EN
      exp_lock = '{0, 0, 0, 0, 1};
`else
      exp_lock = '{0, 1, 0, 1, 0};
`endif
      do_reset();
      lock0 = 1'b1;
      contend(5, order);
      lock0 = 1'b0;
      for (int i = 0; i < 5; i++) chk($sformatf("lock order[%0d]", i), order[i], exp_lock[i]);

      chk("strobe overlap", overlap_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

endmodule
